// File: rtl/dp_seq_core.sv
// Multi-cycle data path: IDLE->OPRD->EXEC(1 or DATA_W cycles)->[MEM]->WB; accept->DONE is 3 cycles plus mul/mem time.
// One control word in flight; ctrl_ready_o is high only in IDLE and memory stalls hold the core until mem_ack_i.
module dp_seq_core #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 26,
    parameter int                RF_AW  = 5,
    parameter logic [ADDR_W-1:0] PC_RST = 'h1000,
    parameter logic [ADDR_W-1:0] SP_RST = 'h3ffffff,
    parameter int                CTRL_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ctrl_valid_i,
    output logic              ctrl_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_out_o,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [31:0]       instruction_o,
    output logic              zero_o
);
    localparam int RF_D  = 1 << RF_AW;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_OPRD, S_EXEC, S_MEM, S_WB} state_t;

    state_t              state_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [ADDR_W-1:0]   pc_q, sp_q, pc1_q;
    logic [31:0]         ir_q;
    logic                zero_q;
    logic [DATA_W-1:0]   rf_q [RF_D];
    logic [DATA_W-1:0]   opa_q, opb_q, rs_q, rt_q, res_q, mdat_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ready_q, done_q, req_q, we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   dout_q;

    logic       c_pc_ld, c_ir_ld, c_rf_we, c_rs_zero, c_sp_ld, c_op1_sp;
    logic       c_mem_rd, c_mem_wr, c_ma_sp, c_ma_pc, c_md_rs;
    logic [1:0] c_pc_src, c_wd_src, c_wa_src;
    logic [2:0] c_op2_src;
    logic [3:0] c_alu_op;

    assign c_pc_ld   = ctrl_q[0];
    assign c_pc_src  = ctrl_q[2:1];
    assign c_ir_ld   = ctrl_q[3];
    assign c_rf_we   = ctrl_q[4];
    assign c_wd_src  = ctrl_q[6:5];
    assign c_wa_src  = ctrl_q[8:7];
    assign c_rs_zero = ctrl_q[9];
    assign c_sp_ld   = ctrl_q[10];
    assign c_op1_sp  = ctrl_q[11];
    assign c_op2_src = ctrl_q[14:12];
    assign c_alu_op  = ctrl_q[18:15];
    assign c_mem_rd  = ctrl_q[19];
    assign c_mem_wr  = ctrl_q[20];
    assign c_ma_sp   = ctrl_q[21];
    assign c_ma_pc   = ctrl_q[22];
    assign c_md_rs   = ctrl_q[23];

    logic [RF_AW-1:0]  rs_idx, rt_idx, wa_idx;
    logic [DATA_W-1:0] rs_rd, rt_rd, op1_d, op2_d, alu_d, exec_res_d, wd_d;
    logic [DATA_W-1:0] imm_sx, imm_zx;
    logic [ADDR_W-1:0] ma_d, pc_next_d;
    logic              is_mul, exec_last;

    assign rs_idx = c_rs_zero ? '0 : ir_q[21 +: RF_AW];
    assign rt_idx = ir_q[16 +: RF_AW];
    assign rs_rd  = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_rd  = (rt_idx == '0) ? '0 : rf_q[rt_idx];
    assign imm_sx = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_zx = DATA_W'(ir_q[15:0]);
    assign op1_d  = c_op1_sp ? DATA_W'(sp_q) : rs_rd;

    always_comb begin
        op2_d = '0;
        case (c_op2_src)
            3'd0:    op2_d = rt_rd;
            3'd1:    op2_d = imm_sx;
            3'd2:    op2_d = imm_zx;
            3'd3:    op2_d = DATA_W'(ir_q[10:6]);
            3'd4:    op2_d = DATA_W'(1);
            default: op2_d = '0;
        endcase
    end

    always_comb begin
        alu_d = '0;
        case (c_alu_op)
            4'd0:    alu_d = opa_q + opb_q;
            4'd1:    alu_d = opa_q - opb_q;
            4'd2:    alu_d = opa_q & opb_q;
            4'd3:    alu_d = opa_q | opb_q;
            4'd4:    alu_d = ~(opa_q | opb_q);
            4'd5:    alu_d = DATA_W'($signed(opa_q) < $signed(opb_q));
            4'd6:    alu_d = opa_q << opb_q[4:0];
            4'd7:    alu_d = opa_q >> opb_q[4:0];
            default: alu_d = '0;
        endcase
    end

    // Multiply reuses opa_q/opb_q as shifting multiplicand/multiplier and res_q as accumulator.
    assign is_mul     = (c_alu_op == 4'd8);
    assign exec_res_d = is_mul ? (res_q + (opb_q[0] ? opa_q : '0)) : alu_d;
    assign exec_last  = !is_mul || (cnt_q == CNT_W'(DATA_W - 1));

    // A push (ma_sp with sp_ld) addresses the updated SP; otherwise the current SP.
    always_comb begin
        ma_d = exec_res_d[ADDR_W-1:0];
        if (c_ma_pc)
            ma_d = pc_q;
        else if (c_ma_sp)
            ma_d = c_sp_ld ? exec_res_d[ADDR_W-1:0] : sp_q;
    end

    always_comb begin
        pc_next_d = pc1_q;
        case (c_pc_src)
            2'd0: pc_next_d = pc1_q;
            2'd1: pc_next_d = pc1_q + ADDR_W'(imm_sx);
            2'd2: pc_next_d = rs_q[ADDR_W-1:0];
            2'd3: pc_next_d = ADDR_W'(ir_q[25:0]);
        endcase
    end

    always_comb begin
        wd_d   = res_q;
        wa_idx = '0;
        case (c_wd_src)
            2'd0: wd_d = res_q;
            2'd1: wd_d = mdat_q;
            2'd2: wd_d = DATA_W'({ir_q[15:0], 16'h0000});
            2'd3: wd_d = DATA_W'(pc1_q);
        endcase
        case (c_wa_src)
            2'd0: wa_idx = ir_q[11 +: RF_AW];
            2'd1: wa_idx = ir_q[16 +: RF_AW];
            2'd2: wa_idx = RF_AW'(31);
            2'd3: wa_idx = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            pc_q    <= PC_RST;
            sp_q    <= SP_RST;
            pc1_q   <= '0;
            ir_q    <= '0;
            zero_q  <= 1'b0;
            for (int i = 0; i < RF_D; i++) rf_q[i] <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            res_q   <= '0;
            mdat_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_valid_i) begin
                        ctrl_q  <= ctrl_i;
                        ready_q <= 1'b0;
                        state_q <= S_OPRD;
                    end
                end
                S_OPRD: begin
                    opa_q   <= op1_d;
                    opb_q   <= op2_d;
                    rs_q    <= rs_rd;
                    rt_q    <= rt_rd;
                    pc1_q   <= pc_q + ADDR_W'(1);
                    res_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    res_q <= exec_res_d;
                    if (is_mul) begin
                        opa_q <= opa_q << 1;
                        opb_q <= opb_q >> 1;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (exec_last) begin
                        if (c_mem_rd || c_mem_wr) begin
                            req_q   <= 1'b1;
                            we_q    <= c_mem_wr;
                            addr_q  <= ma_d;
                            dout_q  <= c_md_rs ? rs_q : rt_q;
                            state_q <= S_MEM;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack_i) begin
                        mdat_q  <= data_in_i;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                    if (c_pc_ld) pc_q <= pc_next_d;
                    if (c_sp_ld) sp_q <= res_q[ADDR_W-1:0];
                    if (c_rf_we && (wa_idx != '0)) rf_q[wa_idx] <= wd_d;
                    if (c_ir_ld && c_mem_rd) ir_q <= mdat_q[31:0];
                    if ((c_rf_we && (c_wd_src == 2'd0)) || c_sp_ld) zero_q <= (res_q == '0);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ctrl_ready_o  = ready_q;
    assign done_o        = done_q;
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign addr_o        = addr_q;
    assign data_out_o    = dout_q;
    assign instruction_o = ir_q;
    assign zero_o        = zero_q;
endmodule

// File: tb/tb_dp_seq_core.sv
// Scoreboard bench for dp_seq_core: stimulus queues expected memory and DONE events, monitors pop and compare.
module tb_dp_seq_core;
    logic        clk_i = 1'b0, rst_ni = 1'b0, ctrl_valid_i = 1'b0, mem_ack_i = 1'b0;
    logic [23:0] ctrl_i = '0;
    logic [31:0] data_in_i = '0;
    logic        ctrl_ready_o, done_o, mem_req_o, mem_we_o, zero_o;
    logic [25:0] addr_o;
    logic [31:0] data_out_o, instruction_o;

    dp_seq_core dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_valid_i(ctrl_valid_i), .ctrl_ready_o(ctrl_ready_o),
        .ctrl_i(ctrl_i), .done_o(done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_ack_i(mem_ack_i), .addr_o(addr_o), .data_out_o(data_out_o), .data_in_i(data_in_i),
        .instruction_o(instruction_o), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {int acc; int lat; logic [31:0] ir; logic z;} done_t;
    typedef struct {logic we; logic [25:0] addr; logic [31:0] wdat; int wt; logic [31:0] rdat;} mem_t;
    done_t dq[$];
    mem_t  mq[$];

    localparam logic [23:0] PC_LD = 24'h000001, IR_LD = 24'h000008, RF_WE = 24'h000010;
    localparam logic [23:0] SP_LD = 24'h000400, OP1_SP = 24'h000800;
    localparam logic [23:0] MEM_RD = 24'h080000, MEM_WR = 24'h100000, MA_SP = 24'h200000;
    localparam logic [23:0] MA_PC = 24'h400000, MD_RS = 24'h800000;

    function automatic logic [23:0] fld(input int pos, input int v);
        return 24'(v) << pos;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_mem(input logic we, input logic [25:0] a, input logic [31:0] wd, input int wt, input logic [31:0] rd);
        mem_t m;
        m.we = we; m.addr = a; m.wdat = wd; m.wt = wt; m.rdat = rd;
        mq.push_back(m);
    endtask

    task automatic issue(input logic [23:0] c, input int lat, input logic [31:0] ir, input logic z, input bit track);
        int n;
        done_t d;
        n = 0;
        @(negedge clk_i);
        while (!ctrl_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!ctrl_ready_o) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got 0 expected 1 after %0d cycles", n);
        end else begin
            ctrl_i = c;
            ctrl_valid_i = 1'b1;
            if (track) begin
                d.acc = cyc; d.lat = lat; d.ir = ir; d.z = z;
                dq.push_back(d);
            end
            @(negedge clk_i);
            ctrl_valid_i = 1'b0;
        end
    endtask

    // Memory responder / monitor
    initial begin
        mem_t m;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (rst_ni && mem_req_o && mq.size() > 0) begin
                m = mq.pop_front();
                for (int k = 0; k < m.wt; k++) begin
                    @(negedge clk_i);
                    chk("mem_req_held", mem_req_o, 1);
                end
                chk("mem_we", mem_we_o, m.we);
                chk("mem_addr", addr_o, m.addr);
                if (m.we) chk("mem_wdat", data_out_o, m.wdat);
                data_in_i = m.rdat;
                mem_ack_i = 1'b1;
            end
        end
    end

    // DONE monitor: latency, then committed IR and ZERO one cycle later
    initial begin
        done_t d;
        forever begin
            @(negedge clk_i);
            if (rst_ni && done_o) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    d = dq.pop_front();
                    chk("done_latency", 64'(cyc - d.acc), 64'(d.lat));
                    @(negedge clk_i);
                    chk("instruction", instruction_o, d.ir);
                    chk("zero", zero_o, d.z);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    localparam logic [23:0] FETCH   = MA_PC | MEM_RD | IR_LD | PC_LD;
    logic [23:0] w_addi, w_sw, w_slt, w_lui, w_addiu, w_mul, w_push, w_rw, w_r0, w_sr0, w_br, w_jr, w_j;

    initial begin
        int n;
        w_addi  = RF_WE | fld(7, 1) | fld(12, 1);
        w_sw    = MEM_WR | fld(12, 1);
        w_slt   = RF_WE | fld(7, 2) | fld(12, 1) | fld(15, 5);
        w_lui   = RF_WE | fld(5, 2) | fld(7, 1);
        w_addiu = RF_WE | fld(7, 1) | fld(12, 2);
        w_mul   = RF_WE | fld(7, 2) | fld(15, 8);
        w_push  = OP1_SP | fld(12, 4) | fld(15, 1) | SP_LD | MEM_WR | MA_SP;
        w_rw    = MA_SP | MEM_RD | MEM_WR;
        w_r0    = RF_WE | fld(7, 3) | fld(12, 2);
        w_sr0   = MEM_WR | MD_RS | fld(12, 2);
        w_j     = PC_LD | fld(1, 3);
        w_br    = PC_LD | fld(1, 1);
        w_jr    = PC_LD | fld(1, 2);

        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", ctrl_ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_dout", data_out_o, 0);
        chk("rst_ir", instruction_o, 0);
        chk("rst_zero", zero_o, 0);

        exp_mem(0, 26'h1000, 0, 0, 32'h2003000A); issue(FETCH, 4, 32'h2003000A, 0, 1);
        issue(w_addi, 3, 32'h2003000A, 0, 1);                                        // r3 = 10
        exp_mem(0, 26'h1001, 0, 4, 32'h8C450004); issue(FETCH, 8, 32'h8C450004, 0, 1);
        exp_mem(0, 26'h1002, 0, 1, 32'h2065FFFF); issue(FETCH, 5, 32'h2065FFFF, 0, 1);
        issue(w_addi, 3, 32'h2065FFFF, 0, 1);                                        // r5 = 9
        exp_mem(1, 26'h9, 32'h9, 2, 0);           issue(w_sw, 6, 32'h2065FFFF, 0, 1);
        issue(w_slt, 3, 32'h2065FFFF, 1, 1);                                         // r31 = 0
        exp_mem(0, 26'h1003, 0, 0, 32'h3CE70001); issue(FETCH, 4, 32'h3CE70001, 1, 1);
        issue(w_lui, 3, 32'h3CE70001, 1, 1);                                         // r7 = 0x10000
        issue(w_addiu, 3, 32'h3CE70001, 0, 1);                                       // r7 = 0x10001
        exp_mem(0, 26'h1004, 0, 0, 32'h3CE60001); issue(FETCH, 4, 32'h3CE60001, 0, 1);
        issue(w_lui, 3, 32'h3CE60001, 0, 1);                                         // r6 = 0x10000
        issue(w_mul, 34, 32'h3CE60001, 0, 1);                                        // r31 = 0x10000
        exp_mem(0, 26'h1005, 0, 0, 32'hAFFF0000); issue(FETCH, 4, 32'hAFFF0000, 0, 1);
        exp_mem(1, 26'h0010000, 32'h00010000, 0, 0); issue(w_sw, 4, 32'hAFFF0000, 0, 1);
        exp_mem(1, 26'h3fffffe, 32'h00010000, 0, 0); issue(w_push, 4, 32'hAFFF0000, 0, 1);
        exp_mem(1, 26'h3fffffe, 32'h00010000, 1, 0); issue(w_rw, 5, 32'hAFFF0000, 0, 1);
        issue(IR_LD, 3, 32'hAFFF0000, 0, 1);
        exp_mem(0, 26'h1006, 0, 0, 32'h0BFFFFFF); issue(FETCH, 4, 32'h0BFFFFFF, 0, 1);
        issue(w_j, 3, 32'h0BFFFFFF, 0, 1);                                           // PC = 0x3ffffff
        exp_mem(0, 26'h3ffffff, 0, 0, 32'h20000055); issue(FETCH, 4, 32'h20000055, 0, 1);

        issue(w_r0, 3, 32'h20000055, 0, 1);
        ctrl_i = FETCH;
        ctrl_valid_i = 1'b1;
        chk("ready_in_oprd", ctrl_ready_o, 0);
        @(negedge clk_i);
        chk("ready_in_exec", ctrl_ready_o, 0);
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;

        exp_mem(1, 26'h55, 32'h0, 0, 0);          issue(w_sr0, 4, 32'h20000055, 0, 1);
        issue(w_br, 3, 32'h20000055, 0, 1);                                          // PC = 0x56
        exp_mem(0, 26'h56, 0, 0, 32'h00E00000);   issue(FETCH, 4, 32'h00E00000, 0, 1);
        issue(w_jr, 3, 32'h00E00000, 0, 1);                                          // PC = r7

        issue(FETCH, 0, 0, 0, 0);
        n = 0;
        while (!mem_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("jr_fetch_req", mem_req_o, 1);
        chk("jr_fetch_addr", addr_o, 26'h0010001);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_req", mem_req_o, 0);
        chk("arst_ready", ctrl_ready_o, 1);
        chk("arst_addr", addr_o, 0);
        chk("arst_ir", instruction_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        exp_mem(0, 26'h1000, 0, 0, 32'h12345678); issue(FETCH, 4, 32'h12345678, 0, 1);

        n = 0;
        while ((dq.size() != 0 || mq.size() != 0) && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        chk("done_queue_empty", 64'(dq.size()), 0);
        chk("mem_queue_empty", 64'(mq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
